// File: rtl/hamming_secded_decoder.sv
// SECDED (extended Hamming) decoder with a two-stage valid/ready pipeline.
// Corrects single-bit errors, flags double/multi-bit errors and counts both kinds of event.
module hamming_secded_decoder #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16,
    localparam int PAR_W = (DATA_W <= 4)   ? 3 :
                           (DATA_W <= 11)  ? 4 :
                           (DATA_W <= 26)  ? 5 :
                           (DATA_W <= 57)  ? 6 :
                           (DATA_W <= 120) ? 7 :
                           (DATA_W <= 247) ? 8 : 9,
    localparam int N     = DATA_W + PAR_W,
    localparam int CW_W  = N + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [CW_W-1:0]   s_cw,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_corrected,
    output logic              m_uncorrectable,
    output logic [PAR_W-1:0]  m_syndrome,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  cnt_corr,
    output logic [CNT_W-1:0]  cnt_uncorr
);

    // Hamming position (1-based) of data bit d: the d-th non-power-of-two position.
    function automatic int data_pos(input int d);
        int pos;
        int cnt;
        pos = 0;
        cnt = 0;
        for (int i = 1; i <= N; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (cnt == d) pos = i;
                cnt++;
            end
        end
        return pos;
    endfunction

    logic [PAR_W-1:0]  syn_in;
    logic              par_in;
    logic [DATA_W-1:0] raw_in;

    logic              v1;
    logic [DATA_W-1:0] raw1;
    logic [PAR_W-1:0]  syn1;
    logic              par1;

    logic              v2;
    logic [DATA_W-1:0] data2;
    logic              corr2;
    logic              unc2;
    logic [PAR_W-1:0]  syn2;

    logic              load2;
    logic              single_err;
    logic              multi_err;
    logic [DATA_W-1:0] dec_data;
    logic              out_xfer;

    always_comb begin
        syn_in = '0;
        raw_in = '0;
        for (int k = 0; k < PAR_W; k++) begin
            for (int i = 1; i <= N; i++) begin
                if (((i >> k) & 1) != 0) syn_in[k] = syn_in[k] ^ s_cw[i-1];
            end
        end
        par_in = ^s_cw;
        for (int d = 0; d < DATA_W; d++) begin
            raw_in[d] = s_cw[data_pos(d)-1];
        end
    end

    assign load2   = ~v2 | m_ready;
    assign s_ready = ~v1 | load2;

    // Parity bits are consumed by the syndrome, so only raw data travels to stage 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            raw1 <= '0;
            syn1 <= '0;
            par1 <= 1'b0;
        end else if (s_ready) begin
            v1 <= s_valid;
            if (s_valid) begin
                raw1 <= raw_in;
                syn1 <= syn_in;
                par1 <= par_in;
            end
        end
    end

    always_comb begin
        single_err = par1 && (int'(syn1) <= N);
        multi_err  = (!par1 && (syn1 != '0)) || (par1 && (int'(syn1) > N));
        dec_data   = raw1;
        for (int d = 0; d < DATA_W; d++) begin
            if (single_err && (int'(syn1) == data_pos(d))) dec_data[d] = ~raw1[d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            data2 <= '0;
            corr2 <= 1'b0;
            unc2  <= 1'b0;
            syn2  <= '0;
        end else if (load2) begin
            v2 <= v1;
            if (v1) begin
                data2 <= dec_data;
                corr2 <= single_err;
                unc2  <= multi_err;
                syn2  <= syn1;
            end
        end
    end

    assign m_valid         = v2;
    assign m_data          = data2;
    assign m_corrected     = corr2;
    assign m_uncorrectable = unc2;
    assign m_syndrome      = syn2;
    assign out_xfer        = v2 & m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else if (clr_cnt) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else begin
            if (out_xfer && corr2 && (cnt_corr != '1))
                cnt_corr <= cnt_corr + CNT_W'(1);
            if (out_xfer && unc2 && (cnt_uncorr != '1))
                cnt_uncorr <= cnt_uncorr + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Directed bench for hamming_secded_decoder (DATA_W=8); a second instance with 2-bit
// counters shares the stimulus to exercise counter saturation.
module tb_hamming_secded_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        m_ready = 1'b1;
    logic        clr_cnt = 1'b0;
    logic [12:0] s_cw = '0;

    logic        s_ready, m_valid, m_corrected, m_uncorrectable;
    logic [7:0]  m_data;
    logic [3:0]  m_syndrome;
    logic [15:0] cnt_corr, cnt_uncorr;

    logic        sat_s_ready, sat_m_valid, sat_m_corrected, sat_m_uncorrectable;
    logic [7:0]  sat_m_data;
    logic [3:0]  sat_m_syndrome;
    logic [1:0]  sat_cnt_corr, sat_cnt_uncorr;

    int checks = 0;
    int errors = 0;

    logic [12:0] w_cw  [4] = '{13'h0A27, 13'h0F77, 13'h0807, 13'h0004};
    logic [7:0]  w_dat [4] = '{8'hA5, 8'hFF, 8'h81, 8'h00};
    logic [3:0]  w_syn [4] = '{4'd0, 4'd0, 4'd12, 4'd3};
    int          got_n = 0;

    always #5 clk = ~clk;

    hamming_secded_decoder #(.DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_cw(s_cw),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_corrected(m_corrected),
        .m_uncorrectable(m_uncorrectable), .m_syndrome(m_syndrome), .clr_cnt(clr_cnt),
        .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr)
    );

    hamming_secded_decoder #(.DATA_W(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(sat_s_ready), .s_cw(s_cw),
        .m_valid(sat_m_valid), .m_ready(m_ready), .m_data(sat_m_data),
        .m_corrected(sat_m_corrected), .m_uncorrectable(sat_m_uncorrectable),
        .m_syndrome(sat_m_syndrome), .clr_cnt(clr_cnt),
        .cnt_corr(sat_cnt_corr), .cnt_uncorr(sat_cnt_uncorr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // One word through an empty pipeline with m_ready held high.
    task automatic xfer(input string tag, input logic [12:0] cw, input logic [7:0] d,
                        input logic c, input logic u, input logic [3:0] syn);
        s_cw    = cw;
        s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        check({tag, "_lat1"}, 32'(m_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, "_valid"}, 32'(m_valid), 32'd1);
        check({tag, "_data"}, 32'(m_data), 32'(d));
        check({tag, "_corr"}, 32'(m_corrected), 32'(c));
        check({tag, "_uncorr"}, 32'(m_uncorrectable), 32'(u));
        check({tag, "_syn"}, 32'(m_syndrome), 32'(syn));
        check({tag, "_sat_data"}, 32'(sat_m_data), 32'(d));
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_sready", 32'(s_ready), 32'd1);
        check("rst_cnt_corr", 32'(cnt_corr), 32'd0);
        check("rst_cnt_uncorr", 32'(cnt_uncorr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        xfer("t1", 13'h0A27, 8'hA5, 1'b0, 1'b0, 4'd0);
        check("t1_cnt_corr", 32'(cnt_corr), 32'd0);
        xfer("t2", 13'h0A07, 8'hA5, 1'b1, 1'b0, 4'd6);
        check("t2_cnt_corr", 32'(cnt_corr), 32'd1);
        xfer("t3", 13'h1A27, 8'hA5, 1'b1, 1'b0, 4'd0);
        check("t3_cnt_corr", 32'(cnt_corr), 32'd2);
        xfer("t4", 13'h0807, 8'h81, 1'b0, 1'b1, 4'd12);
        check("t4_cnt_uncorr", 32'(cnt_uncorr), 32'd1);
        // Three flips (positions 1,2,12): P=1 with syndrome 15 > N.
        xfer("t4b", 13'h0224, 8'h25, 1'b0, 1'b1, 4'd15);
        check("t4b_cnt_uncorr", 32'(cnt_uncorr), 32'd2);

        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    automatic bit acc = 1'b0;
                    automatic int waitc = 0;
                    s_valid = 1'b1;
                    s_cw    = w_cw[i];
                    while (!acc && waitc < 20) begin
                        @(negedge clk);
                        acc = s_ready;
                        @(posedge clk); #1;
                        waitc++;
                    end
                    if (!acc) check("t5_accept_timeout", 32'd0, 32'd1);
                end
                s_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 14; c++) begin
                    m_ready = !(c >= 2 && c <= 4);
                    @(negedge clk);
                    if (c >= 2 && c <= 4) begin
                        check("t5_stall_valid", 32'(m_valid), 32'd1);
                        check("t5_stall_data", 32'(m_data), 32'hA5);
                        check("t5_stall_syn", 32'(m_syndrome), 32'd0);
                        check("t5_stall_sready", 32'(s_ready), 32'd0);
                    end else if (m_valid && m_ready) begin
                        if (got_n < 4) begin
                            check("t5_data", 32'(m_data), 32'(w_dat[got_n]));
                            check("t5_syn", 32'(m_syndrome), 32'(w_syn[got_n]));
                        end else begin
                            check("t5_extra_word", 32'd1, 32'd0);
                        end
                        got_n++;
                    end
                    @(posedge clk); #1;
                end
            end
        join
        m_ready = 1'b1;
        check("t5_count", 32'(got_n), 32'd4);
        check("t5_cnt_corr", 32'(cnt_corr), 32'd3);
        check("t5_cnt_uncorr", 32'(cnt_uncorr), 32'd3);

        xfer("t6a", 13'h0A07, 8'hA5, 1'b1, 1'b0, 4'd6);
        xfer("t6b", 13'h0004, 8'h00, 1'b1, 1'b0, 4'd3);
        check("t6_cnt_corr", 32'(cnt_corr), 32'd5);
        check("t6_sat_corr", 32'(sat_cnt_corr), 32'd3);
        check("t6_sat_uncorr", 32'(sat_cnt_uncorr), 32'd3);

        s_cw    = 13'h0A07;
        s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(posedge clk); #1;
        check("t6_clr_valid", 32'(m_valid), 32'd1);
        check("t6_clr_corr_flag", 32'(m_corrected), 32'd1);
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        check("t6_clr_cnt_corr", 32'(cnt_corr), 32'd0);
        check("t6_clr_cnt_uncorr", 32'(cnt_uncorr), 32'd0);
        check("t6_clr_sat_corr", 32'(sat_cnt_corr), 32'd0);
        xfer("t6c", 13'h0A07, 8'hA5, 1'b1, 1'b0, 4'd6);
        check("t6_recount", 32'(cnt_corr), 32'd1);

        m_ready = 1'b0;
        s_cw    = 13'h0807;
        s_valid = 1'b1;
        @(posedge clk); #1;
        s_cw = 13'h0A07;
        @(posedge clk); #1;
        s_valid = 1'b0;
        check("t6_full_valid", 32'(m_valid), 32'd1);
        check("t6_full_sready", 32'(s_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(m_valid), 32'd0);
        check("t6_rst_data", 32'(m_data), 32'd0);
        check("t6_rst_uncorr", 32'(m_uncorrectable), 32'd0);
        check("t6_rst_syn", 32'(m_syndrome), 32'd0);
        check("t6_rst_cnt_corr", 32'(cnt_corr), 32'd0);
        check("t6_rst_cnt_uncorr", 32'(cnt_uncorr), 32'd0);
        check("t6_rst_sready", 32'(s_ready), 32'd1);
        @(negedge clk);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("t6_dropped", 32'(m_valid), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
